seq_mult_n: RTL

Parametrised sequential shift-add multiplier with integrated control FSM. It succeeds the fixed 32-bit multiplier datapath and its external controller. It adds a width parameter, signed/unsigned operation, a start/busy/done handshake and optional early termination. It sits between an operand-issuing master and any consumer of a double-width product, and owns all sequencing internally.

---
 rtl/seq_mult_n.sv | 87 ++++++++
 1 files changed

// File: rtl/seq_mult_n.sv
// seq_mult_n: shift-add multiplier with built-in start/busy/done control.
// Signed operands are multiplied as magnitudes and the sign is applied at the end.
module seq_mult_n #(
   parameter int SIZE       = 32,
   parameter int EARLY_EXIT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              signed_mode,
   input  logic [SIZE-1:0]   a,
   input  logic [SIZE-1:0]   b,
   output logic              busy,
   output logic              done,
   output logic [2*SIZE-1:0] prod
);

   localparam int CW = $clog2(SIZE) + 1;
   localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] FINISH = 2'd2;

   logic [1:0]        state;
   logic [2*SIZE-1:0] areg;
   logic [SIZE-1:0]   breg;
   logic [2*SIZE-1:0] acc;
   logic [CW-1:0]     cnt;
   logic              neg;

   logic [SIZE-1:0]   magA;
   logic [SIZE-1:0]   magB;
   logic              lastIter;

   // operand magnitudes and loop-exit condition
   always_comb begin
      magA     = (signed_mode && a[SIZE-1]) ? -a : a;
      magB     = (signed_mode && b[SIZE-1]) ? -b : b;
      lastIter = (cnt == LAST) ||
                 ((EARLY_EXIT != 0) && ((breg >> 1) == '0));
   end

   assign busy = (state == RUN) || (state == FINISH);

   // control FSM and shift-add datapath
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         areg  <= '0;
         breg  <= '0;
         acc   <= '0;
         cnt   <= '0;
         neg   <= 1'b0;
         done  <= 1'b0;
         prod  <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  areg  <= {{SIZE{1'b0}}, magA};
                  breg  <= magB;
                  acc   <= '0;
                  cnt   <= '0;
                  neg   <= signed_mode & (a[SIZE-1] ^ b[SIZE-1]);
                  state <= RUN;
               end
            end
            RUN: begin
               if (breg[0]) acc <= acc + areg;
               areg <= areg << 1;
               breg <= breg >> 1;
               cnt  <= cnt + 1'b1;
               if (lastIter) state <= FINISH;
            end
            FINISH: begin
               prod  <= neg ? -acc : acc;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
